// File: rtl/maria_clock_ctrl_pkg.sv
// Shared types and constants for the Maria clock/interrupt controller.
// Optional profiling counters are enabled by defining MARIA_PROFILE_EN.
package maria_clk_pkg;

    typedef enum logic {
        CLK_FAST = 1'b0,
        CLK_SLOW = 1'b1
    } clk_mode_t;

    localparam int unsigned DEF_FAST_HALF      = 2;
    localparam int unsigned DEF_SLOW_HALF      = 3;
    localparam int unsigned DEF_STRETCH_PERIOD = 110;
    localparam int unsigned DEF_NMI_WIDTH      = 2;
    localparam int unsigned DEF_CNT_W          = 13;
    localparam int unsigned DIV_W              = 8;

    typedef logic [DIV_W-1:0] div_t;

    // Reload value for the pclk divider; a mode change shortens the half by one mclk1.
    function automatic div_t half_reload(clk_mode_t   mode,
                                         logic        shortened,
                                         int unsigned fast_half = DEF_FAST_HALF,
                                         int unsigned slow_half = DEF_SLOW_HALF);
        int unsigned half;
        int unsigned step;
        half = (mode == CLK_SLOW) ? slow_half : fast_half;
        step = shortened ? 2 : 1;
        return (half > step) ? div_t'(half - step) : '0;
    endfunction

endpackage

// File: rtl/maria_clock_ctrl_if.sv
// Control/strobe bundle between the Maria top level and the clock controller.
// The counter fields carry data only when MARIA_PROFILE_EN is defined.
interface maria_clock_ctrl_if #(
    parameter int unsigned CNT_W = 13
);
    logic             stretch_en;
    logic             sel_slow_clock;
    logic             halt_b;
    logic             halt_en;
    logic             drive_AB;
    logic             dli;
    logic             lrc;
    logic             deassert_ready;

    logic             mclk0;
    logic             mclk1;
    logic             tia_clk;
    logic             pclk0;
    logic             pclk1;
    logic             pclk_level;
    logic             pclk_edge;
    logic             int_b;
    logic             ready;
    logic [CNT_W-1:0] cpu_ticks;
    logic [CNT_W-1:0] halted_ticks;
    logic [CNT_W-1:0] driven_ticks;

    modport master (
        output stretch_en, sel_slow_clock, halt_b, halt_en, drive_AB, dli, lrc, deassert_ready,
        input  mclk0, mclk1, tia_clk, pclk0, pclk1, pclk_level, pclk_edge, int_b, ready,
               cpu_ticks, halted_ticks, driven_ticks
    );

    modport slave (
        input  stretch_en, sel_slow_clock, halt_b, halt_en, drive_AB, dli, lrc, deassert_ready,
        output mclk0, mclk1, tia_clk, pclk0, pclk1, pclk_level, pclk_edge, int_b, ready,
               cpu_ticks, halted_ticks, driven_ticks
    );

endinterface

// File: rtl/maria_clock_ctrl_pclk_div.sv
// CPU phase-clock divider: counts mclk1 strobes per half-period, with a
// one-strobe shortening whenever the fast/slow select changes.
module maria_pclk_div
    import maria_clk_pkg::*;
#(
    parameter int unsigned FAST_HALF = DEF_FAST_HALF,
    parameter int unsigned SLOW_HALF = DEF_SLOW_HALF
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic mclk1_i,
    input  logic sel_slow_clock_i,
    output logic pclk0_o,
    output logic pclk1_o,
    output logic pclk_level_o,
    output logic pclk_edge_o
);

    clk_mode_t mode;
    div_t      clock_div_q, clock_div_d;
    logic      level_q, level_d;
    logic      pclk0_q, pclk0_d;
    logic      pclk1_q, pclk1_d;
    logic      sel_prev_q, sel_prev_d;

    assign mode = sel_slow_clock_i ? CLK_SLOW : CLK_FAST;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        clock_div_d = clock_div_q;
        level_d     = level_q;
        pclk0_d     = 1'b0;
        pclk1_d     = 1'b0;
        sel_prev_d  = sel_prev_q;
        if (mclk1_i) begin
            sel_prev_d = sel_slow_clock_i;
            if (clock_div_q != '0) begin
                clock_div_d = clock_div_q - 1'b1;
            end else begin
                level_d     = ~level_q;
                pclk1_d     = level_q;
                pclk0_d     = ~level_q;
                clock_div_d = half_reload(mode, 1'b0, FAST_HALF, SLOW_HALF);
            end
            if (sel_slow_clock_i != sel_prev_q) begin
                clock_div_d = half_reload(mode, 1'b1, FAST_HALF, SLOW_HALF);
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clock_div_q <= '0;
            level_q     <= 1'b0;
            pclk0_q     <= 1'b0;
            pclk1_q     <= 1'b0;
            sel_prev_q  <= 1'b0;
        end else begin
            clock_div_q <= clock_div_d;
            level_q     <= level_d;
            pclk0_q     <= pclk0_d;
            pclk1_q     <= pclk1_d;
            sel_prev_q  <= sel_prev_d;
        end
    end

    assign pclk0_o      = pclk0_q;
    assign pclk1_o      = pclk1_q;
    assign pclk_level_o = level_q;
    assign pclk_edge_o  = (clock_div_q == div_t'(1)) && level_q;

endmodule

// File: rtl/maria_clock_ctrl.sv
// Maria clock/interrupt controller: master phase, PAL stretch, pclk divider,
// DLI-to-NMI shaper and READY latch. Profiling counters need MARIA_PROFILE_EN.
module maria_clock_ctrl
    import maria_clk_pkg::*;
#(
    parameter int unsigned FAST_HALF      = DEF_FAST_HALF,
    parameter int unsigned SLOW_HALF      = DEF_SLOW_HALF,
    parameter int unsigned STRETCH_PERIOD = DEF_STRETCH_PERIOD,
    parameter int unsigned NMI_WIDTH      = DEF_NMI_WIDTH,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic              clk_sys,
    input  logic              reset,
    maria_clock_ctrl_if.slave ctrl
);

    localparam int unsigned     STR_W       = (STRETCH_PERIOD > 2) ? $clog2(STRETCH_PERIOD) : 1;
    localparam logic [STR_W-1:0] STR_LAST   = STR_W'(STRETCH_PERIOD - 1);
    localparam int unsigned     NMI_W       = $clog2(NMI_WIDTH + 2);
    localparam logic [NMI_W-1:0] NMI_IDLE   = NMI_W'(NMI_WIDTH + 1);
    localparam logic [NMI_W-1:0] NMI_LOWMAX = NMI_W'(NMI_WIDTH);

    logic             toggle_q, toggle_d;
    logic             mclk0_q, mclk0_d;
    logic             mclk1_q, mclk1_d;
    logic             tia_q, tia_d;
    logic [STR_W-1:0] stretch_q, stretch_d;
    logic             gap;

    logic             dli_q;
    logic             dli_latch_q, dli_latch_d;
    logic [NMI_W-1:0] nmi_cnt_q, nmi_cnt_d;
    logic             int_b_q;
    logic             ready_q;

    logic             pclk0, pclk1, pclk_level, pclk_edge;

    // Phase generator; the last count of a stretch window emits no strobe and freezes the phase.
    always_comb begin
        gap       = ctrl.stretch_en && (stretch_q == STR_LAST);
        stretch_d = '0;
        if (ctrl.stretch_en && !gap) begin
            stretch_d = stretch_q + 1'b1;
        end
        toggle_d = toggle_q;
        mclk0_d  = 1'b0;
        mclk1_d  = 1'b0;
        if (!gap) begin
            toggle_d = ~toggle_q;
            mclk0_d  = toggle_q;
            mclk1_d  = ~toggle_q;
        end
        tia_d = tia_q;
        if (mclk1_q) begin
            tia_d = 1'b1;
        end else if (mclk0_q) begin
            tia_d = 1'b0;
        end
    end

    // A fresh DLI edge restarts the pulse; the count advances only on unhalted CPU cycles.
    always_comb begin
        dli_latch_d = dli_latch_q;
        nmi_cnt_d   = nmi_cnt_q;
        if (ctrl.dli && !dli_q) begin
            dli_latch_d = 1'b1;
            nmi_cnt_d   = '0;
        end else if (pclk1 && ctrl.halt_b && dli_latch_q) begin
            if (nmi_cnt_q != NMI_IDLE) begin
                nmi_cnt_d = nmi_cnt_q + 1'b1;
            end
            if (nmi_cnt_d == NMI_IDLE) begin
                dli_latch_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            toggle_q    <= 1'b0;
            mclk0_q     <= 1'b0;
            mclk1_q     <= 1'b0;
            tia_q       <= 1'b0;
            stretch_q   <= '0;
            dli_q       <= 1'b0;
            dli_latch_q <= 1'b0;
            nmi_cnt_q   <= NMI_IDLE;
            int_b_q     <= 1'b1;
            ready_q     <= 1'b1;
        end else begin
            toggle_q    <= toggle_d;
            mclk0_q     <= mclk0_d;
            mclk1_q     <= mclk1_d;
            tia_q       <= tia_d;
            stretch_q   <= stretch_d;
            dli_q       <= ctrl.dli;
            dli_latch_q <= dli_latch_d;
            nmi_cnt_q   <= nmi_cnt_d;
            int_b_q     <= ~((nmi_cnt_d != '0) && (nmi_cnt_d <= NMI_LOWMAX));
            if (ctrl.deassert_ready) begin
                ready_q <= 1'b0;
            end else if (ctrl.lrc) begin
                ready_q <= 1'b1;
            end
        end
    end

    maria_pclk_div #(
        .FAST_HALF (FAST_HALF),
        .SLOW_HALF (SLOW_HALF)
    ) u_pclk_div (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .mclk1_i          (mclk1_q),
        .sel_slow_clock_i (ctrl.sel_slow_clock),
        .pclk0_o          (pclk0),
        .pclk1_o          (pclk1),
        .pclk_level_o     (pclk_level),
        .pclk_edge_o      (pclk_edge)
    );

`ifdef MARIA_PROFILE_EN
    logic [CNT_W-1:0] cpu_ticks_q, halted_ticks_q, driven_ticks_q;

    // New line (lrc) clears the counters and takes priority over any increment.
    always_ff @(posedge clk_sys) begin
        if (reset || ctrl.lrc) begin
            cpu_ticks_q    <= '0;
            halted_ticks_q <= '0;
            driven_ticks_q <= '0;
        end else begin
            if (pclk0 && ctrl.halt_b)     cpu_ticks_q    <= cpu_ticks_q + 1'b1;
            if (mclk0_q && ctrl.halt_en)  halted_ticks_q <= halted_ticks_q + 1'b1;
            if (mclk0_q && ctrl.drive_AB) driven_ticks_q <= driven_ticks_q + 1'b1;
        end
    end

    assign ctrl.cpu_ticks    = cpu_ticks_q;
    assign ctrl.halted_ticks = halted_ticks_q;
    assign ctrl.driven_ticks = driven_ticks_q;
`else
    logic unused_profile;
    assign unused_profile    = ^{ctrl.halt_en, ctrl.drive_AB};
    assign ctrl.cpu_ticks    = '0;
    assign ctrl.halted_ticks = '0;
    assign ctrl.driven_ticks = '0;
`endif

    assign ctrl.mclk0      = mclk0_q;
    assign ctrl.mclk1      = mclk1_q;
    assign ctrl.tia_clk    = tia_q;
    assign ctrl.pclk0      = pclk0;
    assign ctrl.pclk1      = pclk1;
    assign ctrl.pclk_level = pclk_level;
    assign ctrl.pclk_edge  = pclk_edge;
    assign ctrl.int_b      = int_b_q;
    assign ctrl.ready      = ready_q;

endmodule

// File: tb/tb_maria_clock_ctrl.sv
// Self-checking bench for maria_clock_ctrl: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model; honours MARIA_PROFILE_EN.
module tb_maria_clock_ctrl;

    localparam int FAST   = 2;
    localparam int SLOW   = 3;
    localparam int PERIOD = 110;
    localparam int NMI_W  = 2;
    localparam int CNT_W  = 13;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    maria_clock_ctrl_if #(.CNT_W(CNT_W)) bus ();

    maria_clock_ctrl #(
        .FAST_HALF      (FAST),
        .SLOW_HALF      (SLOW),
        .STRETCH_PERIOD (PERIOD),
        .NMI_WIDTH      (NMI_W),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ctrl    (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (values the DUT outputs should show after the last edge).
    bit e_m0, e_m1, e_tia, e_p0, e_p1, e_lvl, e_int_b, e_ready;
    int e_cpu, e_hlt, e_drv;
    int strobes;      // master strobes emitted since reset; even index -> mclk1
    int win_pos;      // position inside the stretch window
    int mclk1_left;   // mclk1 strobes still to pass before the next pclk edge
    bit sel_seen;     // select value seen at the previous mclk1
    int nmi_steps;    // pclk1 steps left until the NMI pulse is over (0 = idle)
    bit dli_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit gap, n_p0, n_p1;
        int half;
        if (reset) begin
            strobes = 0; win_pos = 0; mclk1_left = 0; sel_seen = 0; nmi_steps = 0; dli_seen = 0;
            e_m0 = 0; e_m1 = 0; e_tia = 0; e_p0 = 0; e_p1 = 0; e_lvl = 0;
            e_int_b = 1; e_ready = 1; e_cpu = 0; e_hlt = 0; e_drv = 0;
            return;
        end
`ifdef MARIA_PROFILE_EN
        if (bus.lrc) begin
            e_cpu = 0; e_hlt = 0; e_drv = 0;
        end else begin
            if (e_p0 && bus.halt_b)    e_cpu = (e_cpu + 1) % (1 << CNT_W);
            if (e_m0 && bus.halt_en)   e_hlt = (e_hlt + 1) % (1 << CNT_W);
            if (e_m0 && bus.drive_AB)  e_drv = (e_drv + 1) % (1 << CNT_W);
        end
`endif
        if (bus.dli && !dli_seen) nmi_steps = NMI_W + 1;
        else if (e_p1 && bus.halt_b && nmi_steps > 0) nmi_steps--;
        dli_seen = bus.dli;
        e_int_b  = !(nmi_steps >= 1 && nmi_steps <= NMI_W);

        if (bus.deassert_ready) e_ready = 0;
        else if (bus.lrc)       e_ready = 1;

        if (e_m1)      e_tia = 1;
        else if (e_m0) e_tia = 0;

        n_p0 = 0; n_p1 = 0;
        if (e_m1) begin
            half = bus.sel_slow_clock ? SLOW : FAST;
            if (mclk1_left == 0) begin
                n_p1 = e_lvl; n_p0 = !e_lvl; e_lvl = !e_lvl;
                mclk1_left = half - 1;
            end else begin
                mclk1_left--;
            end
            if (bus.sel_slow_clock != sel_seen) mclk1_left = (half >= 2) ? half - 2 : 0;
            sel_seen = bus.sel_slow_clock;
        end
        e_p0 = n_p0; e_p1 = n_p1;

        gap     = bus.stretch_en && (win_pos == PERIOD - 1);
        win_pos = bus.stretch_en ? (win_pos + 1) % PERIOD : 0;
        if (gap) begin
            e_m0 = 0; e_m1 = 0;
        end else begin
            e_m1 = (strobes % 2 == 0); e_m0 = !e_m1; strobes++;
        end
    endtask

    task automatic compare_all();
        check("mclk0", bus.mclk0, e_m0);
        check("mclk1", bus.mclk1, e_m1);
        check("tia_clk", bus.tia_clk, e_tia);
        check("pclk0", bus.pclk0, e_p0);
        check("pclk1", bus.pclk1, e_p1);
        check("pclk_level", bus.pclk_level, e_lvl);
        check("pclk_edge", bus.pclk_edge, (mclk1_left == 1 && e_lvl) ? 1 : 0);
        check("int_b", bus.int_b, e_int_b);
        check("ready", bus.ready, e_ready);
        check("cpu_ticks", bus.cpu_ticks, e_cpu);
        check("halted_ticks", bus.halted_ticks, e_hlt);
        check("driven_ticks", bus.driven_ticks, e_drv);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_sys);
        #1;
        compare_all();
    endtask

    task automatic pclk0_period(output int period);
        int t0;
        t0 = -1;
        period = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.pclk0) begin
                if (t0 < 0) t0 = k;
                else begin
                    period = k - t0;
                    break;
                end
            end
        end
    endtask

    task automatic dli_pulse();
        bus.dli = 1'b1;
        tick();
        bus.dli = 1'b0;
    endtask

    task automatic wait_int_low();
        for (int k = 0; k < 40; k++) begin
            if (!bus.int_b) break;
            tick();
        end
        check("nmi_asserted", bus.int_b, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int period, low_cnt, cnt0, gaps, seen;
        bus.stretch_en = 0; bus.sel_slow_clock = 0; bus.halt_b = 1; bus.halt_en = 0;
        bus.drive_AB = 0; bus.dli = 0; bus.lrc = 0; bus.deassert_ready = 0;
        reset = 1;
        repeat (3) tick();
        check("rst_int_b", bus.int_b, 1);
        check("rst_ready", bus.ready, 1);
        check("rst_mclk", {bus.mclk0, bus.mclk1, bus.tia_clk}, 0);
        check("rst_pclk", {bus.pclk0, bus.pclk1, bus.pclk_level}, 0);
        reset = 0;

        // Fast mode, stretch off.
        repeat (20) tick();
        pclk0_period(period);
        check("fast_pclk0_period", period, 8);

        // Slow mode held.
        bus.sel_slow_clock = 1;
        repeat (40) tick();
        pclk0_period(period);
        check("slow_pclk0_period", period, 12);

        // Select change in the middle of a half-period.
        for (int k = 0; k < 4; k++) begin
            repeat (3 + k) tick();
            bus.sel_slow_clock = ~bus.sel_slow_clock;
            repeat (30) tick();
        end
        bus.sel_slow_clock = 0;

        // PAL stretch window.
        bus.stretch_en = 1;
        repeat (150) tick();
        cnt0 = 0; gaps = 0;
        for (int k = 0; k < PERIOD; k++) begin
            tick();
            if (bus.mclk0) cnt0++;
            if (!bus.mclk0 && !bus.mclk1) gaps++;
        end
        check("stretch_gaps", gaps, 1);
        check("stretch_mclk0_54_55", (cnt0 == 54 || cnt0 == 55) ? 1 : 0, 1);
        bus.stretch_en = 0;
        repeat (30) tick();

        // NMI width with halt_b high.
        dli_pulse();
        wait_int_low();
        low_cnt = 0;
        while (!bus.int_b && low_cnt < 200) begin
            low_cnt++;
            tick();
        end
        check("nmi_low_cycles", low_cnt, 2 * 8);

        // Halt for three CPU cycles inside the pulse.
        repeat (20) tick();
        dli_pulse();
        wait_int_low();
        low_cnt = 0;
        while (!bus.int_b && low_cnt < 200) begin
            low_cnt++;
            if (low_cnt == 1)  bus.halt_b = 0;
            if (low_cnt == 25) bus.halt_b = 1;
            tick();
        end
        bus.halt_b = 1;
        check("nmi_low_cycles_halted", low_cnt, 5 * 8);

        // Re-trigger while low.
        repeat (20) tick();
        dli_pulse();
        wait_int_low();
        repeat (9) tick();
        dli_pulse();
        repeat (40) tick();

        // READY priority.
        bus.deassert_ready = 1; bus.lrc = 1;
        tick();
        check("ready_both", bus.ready, 0);
        bus.deassert_ready = 0;
        tick();
        check("ready_lrc", bus.ready, 1);
        bus.lrc = 0;

        // Reset in the middle of an NMI pulse.
        dli_pulse();
        wait_int_low();
        bus.deassert_ready = 1;
        tick();
        bus.deassert_ready = 0;
        reset = 1;
        tick();
        check("rst_mid_int_b", bus.int_b, 1);
        check("rst_mid_ready", bus.ready, 1);
        check("rst_mid_pclk", {bus.pclk0, bus.pclk1, bus.pclk_level}, 0);
        reset = 0;
        repeat (20) tick();

        // Profiling: count 100 pclk0 after a new line.
        bus.halt_b = 1; bus.halt_en = 1; bus.drive_AB = 1;
        bus.lrc = 1;
        tick();
        bus.lrc = 0;
        seen = 0;
        for (int k = 0; k < 2000 && seen < 100; k++) begin
            if (bus.pclk0) seen++;
            if (seen < 100) tick();
        end
        check("pclk0_seen", seen, 100);
        tick();
`ifdef MARIA_PROFILE_EN
        check("cpu_ticks_100", bus.cpu_ticks, 100);
`else
        check("cpu_ticks_off", bus.cpu_ticks, 0);
        check("halted_ticks_off", bus.halted_ticks, 0);
        check("driven_ticks_off", bus.driven_ticks, 0);
`endif
        bus.lrc = 1;
        tick();
        check("cpu_ticks_lrc", bus.cpu_ticks, 0);
        bus.lrc = 0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) bus.stretch_en = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) bus.sel_slow_clock = ~bus.sel_slow_clock;
            if ($urandom_range(0, 29) == 0) bus.dli = ~bus.dli;
            bus.halt_b         = ($urandom_range(0, 7) != 0);
            bus.halt_en        = ($urandom_range(0, 1) == 1);
            bus.drive_AB       = ($urandom_range(0, 1) == 1);
            bus.lrc            = ($urandom_range(0, 49) == 0);
            bus.deassert_ready = ($urandom_range(0, 39) == 0);
            reset              = ($urandom_range(0, 799) == 0);
            tick();
        end
        reset = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
